// File: rtl/des_key_sched_if.sv
// Key-load / round-key handshake bundle between the DES key scheduler and the round datapath.
interface des_key_sched_if;
  logic [63:0] key_i;
  logic        dec_i;
  logic        start_i;
  logic        abort_i;
  logic [47:0] rk_o;
  logic [3:0]  rk_idx_o;
  logic        rk_valid_o;
  logic        rk_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        parity_err_o;

  modport master (
    output key_i, dec_i, start_i, abort_i, rk_ready_i,
    input  rk_o, rk_idx_o, rk_valid_o, busy_o, done_o, parity_err_o
  );

  modport slave (
    input  key_i, dec_i, start_i, abort_i, rk_ready_i,
    output rk_o, rk_idx_o, rk_valid_o, busy_o, done_o, parity_err_o
  );
endinterface

// File: rtl/des_key_sched_seq.sv
// Sequential DES round-key scheduler: PC-1 on load, then one PC-2 round key per handshake.
// Optional key parity check enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched_seq (
  input  logic           clk,
  input  logic           rst_n,
  des_key_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  // DES numbers bits MSB-first from 1, so table entry n selects vector bit (width - n).
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) r[55 - i] = key[64 - int'(PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] r;
    cd = {c, d};
    r  = 48'd0;
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - int'(PC2_TAB[i])];
    return r;
  endfunction

  // Shift schedule s[j+1] indexed by j = 0..15.
  function automatic logic [1:0] shift_amt(input logic [3:0] j);
    logic [1:0] r;
    case (j)
      4'd0, 4'd1, 4'd8, 4'd15: r = 2'd1;
      default:                 r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] r;
    case (n)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^key[8*b +: 8]);
    return ok;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [55:0] kpc1_r;
  logic        dec_r;
  logic [27:0] c_r, d_r, c_nxt_s, d_nxt_s;
  logic [3:0]  idx_r, idx_nxt_s;
  logic [47:0] rk_r;
  logic        valid_r, busy_r, done_r, perr_r, perr_nxt_s;
  logic        accept_s, hs_s, last_s;

  // Next-state and C/D/index update.
  always_comb begin
    state_nxt_s = state_r;
    c_nxt_s     = c_r;
    d_nxt_s     = d_r;
    idx_nxt_s   = idx_r;
    perr_nxt_s  = perr_r;
    accept_s    = 1'b0;
    hs_s        = valid_r & bus.rk_ready_i;
    last_s      = dec_r ? (idx_r == 4'd0) : (idx_r == 4'd15);
    if (bus.abort_i) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_i) begin
`ifdef DES_KEY_PARITY_CHK_EN
            if (key_parity_ok(bus.key_i)) begin
              accept_s    = 1'b1;
              perr_nxt_s  = 1'b0;
              state_nxt_s = LOAD;
            end else begin
              perr_nxt_s  = 1'b1;
            end
`else
            accept_s    = 1'b1;
            perr_nxt_s  = 1'b0;
            state_nxt_s = LOAD;
`endif
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOAD: begin
          state_nxt_s = RUN;
          // C16/D16 equal C0/D0, so decrypt starts straight from the PC-1 halves.
          if (dec_r) begin
            c_nxt_s   = kpc1_r[55:28];
            d_nxt_s   = kpc1_r[27:0];
            idx_nxt_s = 4'd15;
          end else begin
            c_nxt_s   = rotl(kpc1_r[55:28], 2'd1);
            d_nxt_s   = rotl(kpc1_r[27:0], 2'd1);
            idx_nxt_s = 4'd0;
          end
        end
        RUN: begin
          if (hs_s) begin
            if (last_s) begin
              state_nxt_s = DONE;
            end else if (dec_r) begin
              c_nxt_s   = rotr(c_r, shift_amt(idx_r));
              d_nxt_s   = rotr(d_r, shift_amt(idx_r));
              idx_nxt_s = idx_r - 4'd1;
            end else begin
              c_nxt_s   = rotl(c_r, shift_amt(idx_r + 4'd1));
              d_nxt_s   = rotl(d_r, shift_amt(idx_r + 4'd1));
              idx_nxt_s = idx_r + 4'd1;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath and registered status outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kpc1_r  <= 56'd0;
      dec_r   <= 1'b0;
      c_r     <= 28'd0;
      d_r     <= 28'd0;
      idx_r   <= 4'd0;
      rk_r    <= 48'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      perr_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        kpc1_r <= pc1(bus.key_i);
        dec_r  <= bus.dec_i;
      end
      c_r     <= c_nxt_s;
      d_r     <= d_nxt_s;
      idx_r   <= idx_nxt_s;
      rk_r    <= pc2(c_nxt_s, d_nxt_s);
      valid_r <= (state_nxt_s == RUN);
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      perr_r  <= perr_nxt_s;
    end
  end

  assign bus.rk_o         = rk_r;
  assign bus.rk_idx_o     = idx_r;
  assign bus.rk_valid_o   = valid_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.parity_err_o = perr_r;
endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential DES round-key scheduler.
- Accepts a 64-bit key and applies PC-1, then emits the 16 PC-2-compressed 48-bit round keys one per handshake.
- Supports encrypt order (K1..K16, left rotations) or decrypt order (K16..K1, right rotations).
- Feeds the round datapath in both cipher directions, replacing a precomputed 16-entry key table.

Parameters:
- None. All DES tables are fixed constants.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_i  input  64  cipher key; key_i[63] = DES bit 1, parity bits included
- dec_i  input  1  sampled with start_i: 1 = decrypt order (K16 first), 0 = encrypt order (K1 first)
- start_i  input  1  load request, accepted only in IDLE
- abort_i  input  1  synchronous abort to IDLE
- rk_o  output  48  current round key; rk_o[47] = PC-2 output bit 1
- rk_idx_o  output  4  DES key number minus 1 for rk_o (K1 = 0, K16 = 15)
- rk_valid_o  output  1  rk_o valid
- rk_ready_i  input  1  consumer accepts rk_o
- busy_o  output  1  high in LOAD, RUN and DONE
- done_o  output  1  one-cycle pulse after the 16th key is accepted
- parity_err_o  output  1  key parity fault flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n = 0): state IDLE; C/D registers 0; rk_o 0; rk_idx_o 0; rk_valid_o 0; busy_o 0; done_o 0; parity_err_o 0.
- States and transitions:
  - IDLE -> LOAD on start_i.
  - LOAD -> RUN after one cycle.
  - RUN -> DONE on the 16th handshake.
  - DONE -> IDLE after one cycle.
- IDLE accept: key_i and dec_i are registered on start_i = 1. start_i outside IDLE is ignored, with no effect on the current sequence.
- LOAD: C0/D0 = PC-1(key) split into two 28-bit halves.
  - Encrypt: C/D <= rotl1(C0), rotl1(D0), giving K1.
  - Decrypt: C/D <= C0, D0, since C16 = C0 and D16 = D0, giving K16.
  - rk_idx_o <= 0 (encrypt) or 15 (decrypt).
- RUN: rk_valid_o = 1. rk_o = PC-2(C,D), driven from registered C/D only and held stable while rk_valid_o && !rk_ready_i.
- Handshake: occurs in any cycle with rk_valid_o && rk_ready_i. Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt, current Kj: C/D rotate left by s[j+1]; rk_idx_o increments.
  - Decrypt, current Kj: C/D rotate right by s[j]; rk_idx_o decrements.
  - Throughput: one key per cycle when rk_ready_i is held high.
  - Latency: start_i accepted at cycle 0, first rk_valid_o at cycle 2.
- Last key: the handshake on K16 (encrypt) or K1 (decrypt) moves to DONE. rk_valid_o = 0 in the next cycle, done_o = 1 for exactly that cycle, busy_o still 1. Then IDLE.
- rk_idx_o does not wrap. Handshakes are impossible outside RUN.
- abort_i: in LOAD, RUN or DONE, state -> IDLE next cycle, rk_valid_o = 0, no done_o. abort_i has priority over a same-cycle handshake and over start_i.
- rst_n mid-sequence: immediate return to reset values. No partial state survives.
- C/D arithmetic: 28-bit cyclic rotation only, no carry.

Optional Feature:
- Macro: DES_KEY_PARITY_CHK_EN.
- Defined:
  - On start_i in IDLE, each key_i byte is checked for odd parity.
  - Any even byte: parity_err_o <= 1 (sticky until the next accepted start or reset), start is rejected and the block stays IDLE with busy_o = 0.
  - A good key clears parity_err_o and proceeds normally.
- Undefined: parity_err_o tied 0, parity bits ignored.

Test Plan:
- Encrypt order: key 0x133457799BBCDFF1, dec_i = 0, rk_ready_i = 1 -> first rk_o = 0x1B02EFFC7072 at idx 0, then 0x79AED9DBC9E5 at idx 1, 0xCB3D8B0E17F5 at idx 15; done_o pulses one cycle after idx 15 is accepted.
- Decrypt order: same key, dec_i = 1 -> rk_o sequence 0xCB3D8B0E17F5 (idx 15), 0xBF918D3D3F0A (idx 14) ... 0x1B02EFFC7072 (idx 0), then done_o.
- Backpressure: rk_ready_i random 50 % -> rk_o/rk_idx_o stable while stalled; exactly 16 handshakes; sequence identical to the unstalled run.
- Abort/start collisions:
  - abort_i asserted with a handshake at idx 5 -> IDLE, no done_o.
  - start_i during RUN -> ignored.
  - rst_n low at idx 8 -> all outputs return to 0 asynchronously.
- Parity (macro defined): key 0x123457799BBCDFF1 -> parity_err_o = 1, busy_o stays 0; then key 0x133457799BBCDFF1 -> parity_err_o = 0 and normal sequence.
